// File: rtl/hw13_pkg.sv
// hw13_pkg: shared widths, byte/word types and serializer state encoding
package hw13_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, FIRST, SECOND} ser_state_t;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/hw13_word_serializer.sv
// hw13_word_serializer: 16-bit word to byte-pair serializer; HW13_WORD_COUNT_EN adds word_count
module hw13_word_serializer
  import hw13_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic  clock,
  input  logic  reset,
  input  word_t in_data,
  input  logic  in_valid,
  output logic  in_ready,
  output byte_t out_data,
  output logic  out_valid,
  input  logic  out_ready,
`ifdef HW13_WORD_COUNT_EN
  output logic [15:0] word_count,
`endif
  output logic  busy
);
  ser_state_t state, state_nx;
  word_t word_q;
  byte_t first_byte, second_byte;
  logic load;
  assign first_byte  = MSB_FIRST ? word_q[15:8] : word_q[7:0];
  assign second_byte = MSB_FIRST ? word_q[7:0] : word_q[15:8];
  always_comb begin
    in_ready  = (state == IDLE) || (state == SECOND && out_ready);
    out_valid = state != IDLE;
    out_data  = state == FIRST ? first_byte : state == SECOND ? second_byte : byte_t'(0);
    busy      = state != IDLE;
    load      = in_valid && in_ready;
    state_nx  = load ? FIRST :
                (state == FIRST && out_ready) ? SECOND :
                (state == SECOND && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      word_q <= '0;
    end else begin
      state <= state_nx;
      if (load) word_q <= in_data;
    end
  end
`ifdef HW13_WORD_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) word_count <= '0;
    else if (state == SECOND && out_ready) word_count <= word_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_hw13_word_serializer.sv
// tb_hw13_word_serializer: random and directed checks of both byte orders against a byte-queue model
module tb_hw13_word_serializer;
  logic clock = 1'b0;
  logic reset, in_valid, out_ready;
  logic [15:0] in_data;
  logic in_ready1, out_valid1, busy1, in_ready0, out_valid0, busy0;
  logic [7:0] out_data1, out_data0;
`ifdef HW13_WORD_COUNT_EN
  logic [15:0] word_count1, word_count0;
`endif
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  logic [15:0] exp_cnt = 16'h0000;

  always #5 clock = ~clock;

  hw13_word_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
`ifdef HW13_WORD_COUNT_EN
    .word_count(word_count1),
`endif
    .busy(busy1)
  );

  hw13_word_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
`ifdef HW13_WORD_COUNT_EN
    .word_count(word_count0),
`endif
    .busy(busy0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit iv, input logic [15:0] id, input bit ordy, input bit rs);
    bit exp_ir, exp_ov, in_x, out_x, last;
    @(negedge clock);
    in_valid = iv;
    in_data = id;
    out_ready = ordy;
    reset = rs;
    #1;
    exp_ov = q1.size() != 0;
    exp_ir = q1.size() == 0 || (q1.size() == 1 && ordy);
    if (armed) begin
      check("in_ready1", in_ready1, exp_ir);
      check("in_ready0", in_ready0, exp_ir);
      check("out_valid1", out_valid1, exp_ov);
      check("out_valid0", out_valid0, exp_ov);
      check("busy1", busy1, exp_ov);
      check("busy0", busy0, exp_ov);
      check("out_data1", out_data1, exp_ov ? q1[0] : 8'h00);
      check("out_data0", out_data0, exp_ov ? q0[0] : 8'h00);
`ifdef HW13_WORD_COUNT_EN
      check("word_count1", word_count1, exp_cnt);
      check("word_count0", word_count0, exp_cnt);
`endif
    end
    in_x = iv && exp_ir && !rs;
    out_x = ordy && exp_ov && !rs;
    last = q1.size() == 1;
    @(posedge clock);
    if (rs) begin
      q1.delete();
      q0.delete();
      exp_cnt = 16'h0000;
      armed = 1'b1;
    end else begin
      if (out_x) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
        if (last) exp_cnt = exp_cnt + 16'd1;
      end
      if (in_x) begin
        q1.push_back(id[15:8]);
        q1.push_back(id[7:0]);
        q0.push_back(id[7:0]);
        q0.push_back(id[15:8]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    out_ready = 1'b0;
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 1, 0);
    // single word, byte order visible on both instances
    cycle(1, 16'hA55A, 1, 0);
    repeat (3) cycle(0, 16'h0, 1, 0);
    // back-to-back words with a stall-free consumer
    cycle(1, 16'h1234, 1, 0);
    repeat (3) cycle(1, 16'hBEEF, 1, 0);
    repeat (3) cycle(0, 16'h0, 1, 0);
    // backpressure in both byte phases
    cycle(1, 16'hC0DE, 0, 0);
    repeat (3) cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 1, 0);
    repeat (2) cycle(0, 16'h0, 0, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 0);
    // in_data changes while not ready
    cycle(1, 16'h1111, 0, 0);
    repeat (2) cycle(1, 16'h2222, 0, 0);
    cycle(1, 16'h2222, 1, 0);
    cycle(0, 16'h2222, 1, 0);
    cycle(0, 16'h0, 1, 0);
    // reset during the second byte, then reset racing in_valid
    cycle(1, 16'hABCD, 1, 0);
    cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 1);
    cycle(0, 16'h0, 1, 0);
    cycle(1, 16'hFFFF, 1, 1);
    cycle(0, 16'h0, 1, 0);
`ifdef HW13_WORD_COUNT_EN
    @(negedge clock);
    force dut1.word_count = 16'hFFFE;
    force dut0.word_count = 16'hFFFE;
    #1;
    release dut1.word_count;
    release dut0.word_count;
    exp_cnt = 16'hFFFE;
    repeat (2) cycle(1, 16'h5AA5, 1, 0);
    repeat (4) cycle(0, 16'h0, 1, 0);
    cycle(0, 16'h0, 1, 1);
    cycle(0, 16'h0, 1, 0);
`endif
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    cycle(0, 16'h0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
